external_io_fifo: RTL and testbench
===================================

Name: external_io_fifo

Overview:
Parametrised successor to `external_io`. It is the host-facing SPI front end for the shapool core.
- SPI0 loads the job configuration.
- SPI1 loads or daisy-chains the device configuration, and reads back results.
- Results come from a RESULT_DEPTH-entry FIFO, so several shapool successes are kept between host reads instead of one.
- All SPI inputs are oversampled in the `clk` domain; there is no second clock.

Parameters:
- JOB_CONFIG_WIDTH, 8: job configuration register width in bits (>=2).
- DEVICE_CONFIG_WIDTH, 8: device configuration register width in bits (>=2).
- RESULT_WIDTH, 40: width of one result record (match flags concatenated with nonce).
- RESULT_DEPTH, 4: number of FIFO entries; must be a power of 2, >=2.
- SYNC_STAGES, 2: synchroniser flops on sck0/sdi0/cs0_n/sck1/sdi1/cs1_n (>=2).

Ports:
- clk  in  1  system clock; must run at least 4x the sck frequency.
- reset  in  1  synchronous, active-high reset.
- sck0  in  1  SPI0 clock, mode 0.
- sdi0  in  1  SPI0 data in.
- cs0_n  in  1  SPI0 chip select, active low.
- sck1  in  1  SPI1 clock, mode 0.
- sdi1  in  1  SPI1 data in.
- sdo1  out  1  SPI1 data out.
- cs1_n  in  1  SPI1 chip select, active low.
- device_config  out  DEVICE_CONFIG_WIDTH  committed device configuration.
- job_config  out  JOB_CONFIG_WIDTH  committed job configuration.
- core_reset_n  out  1  hold-off to the shapool core, active low.
- shapool_success  in  1  success flag; level input, rising edge pushes.
- shapool_result  in  RESULT_WIDTH  result record, valid while shapool_success is high.
- result_count  out  $clog2(RESULT_DEPTH+1)  current FIFO occupancy.
- overflow  out  1  sticky flag: a result was dropped.
- ready  out  1  FIFO non-empty.

Behaviour:
Reset values
- job_config = 0, device_config = 0, sdo1 = 0, core_reset_n = 0.
- result_count = 0, overflow = 0, ready = 0.
- FIFO emptied, shift registers and bit counters cleared.

Input synchronisation
- Each SPI input passes through SYNC_STAGES flops.
- sck and cs edges are detected on the synchronised values.
- Latency from a pin edge to its internal event is SYNC_STAGES+1 clk.
- A cs_n low that is held across reset is ignored. A new transaction needs a fresh cs_n falling edge after reset.

SPI0 transaction
- Starts on a cs0_n falling edge: the shadow register is cleared and the bit count set to 0.
- On each sck0 rising edge: shadow <= {shadow[JOB_CONFIG_WIDTH-2:0], sdi0}; the bit count increments, saturating.
- On the cs0_n rising edge:
  - if the bit count >= JOB_CONFIG_WIDTH, job_config <= shadow (the last JOB_CONFIG_WIDTH bits, MSB first) in that same cycle;
  - otherwise the data is discarded and job_config is unchanged.
- core_reset_n = 0 while reset is high, while synchronised cs0_n is low, and for one clk after an SPI0 commit. It is 1 otherwise.

SPI1 mode is latched at the cs1_n falling edge:
- CONFIG mode when the FIFO is empty.
- READ mode when the FIFO is non-empty.

SPI1 CONFIG mode
- At cs1_n fall the shift register is loaded with the current device_config, and sdo1 = its MSB.
- On each sck1 rising edge: sample sdi1 into the LSB.
- On each sck1 falling edge: shift left, and sdo1 takes the new MSB. This gives daisy-chain passthrough.
- On cs1_n rise: commit to device_config only if the bit count >= DEVICE_CONFIG_WIDTH; otherwise discard.

SPI1 READ mode
- At cs1_n fall the shift register is loaded with the FIFO head; sdo1 = bit RESULT_WIDTH-1.
- sdo1 is valid SYNC_STAGES+2 clk after the cs1_n pin falls. The host must wait at least that long before the first sck1 rise.
- On each sck1 falling edge: shift left, zero fill. sdi1 is ignored.
- On cs1_n rise:
  - if the count of sck1 rising edges >= RESULT_WIDTH, pop the head;
  - otherwise the read was aborted and the entry is retained.
- device_config is untouched in READ mode.

sdo1 while idle
- sdo1 = 0 whenever synchronised cs1_n is high.

FIFO
- Push happens on the registered rising edge of shapool_success, capturing shapool_result in that cycle.
- If the FIFO is full and there is no pop in the same cycle: the result is dropped, overflow is set (sticky until reset) and the contents are unchanged.
- Push and pop in the same cycle are both performed; a push to a full FIFO is accepted when a pop occurs that cycle.
- Read and write pointers wrap modulo RESULT_DEPTH.
- ready and result_count update on the clk after a push or pop.

Simultaneous SPI0 and SPI1 activity is independent and allowed.

Test Plan:
- Reset, then hold cs0_n low and shift 8'hAA MSB-first on SPI0, then raise cs0_n -> core_reset_n is low throughout; job_config = 8'hAA after cs0_n rise; core_reset_n = 1 two clk later.
- SPI0 sends only 5 bits, then cs0_n rises -> job_config keeps its prior 8'hAA.
- FIFO empty; SPI1 shifts in 8'h5A with device_config = 8'hAA -> sdo1 streams 1010_1010; device_config = 8'h5A after cs1_n rise.
- Pulse shapool_success with 40'hAA_EEDDCCBB, then with 40'h11_22334455 -> result_count = 2, ready = 1. Two full 40-bit SPI1 reads return the records in that order; then ready = 0 and result_count = 0.
- Push one result, abort the read after 12 bits, then do a full read -> the full read returns the same record; result_count goes 1 -> 1 -> 0.
- Push 5 results with depth 4 -> overflow = 1, result_count = 4, the 5th is lost. Assert reset mid-read -> all outputs return to reset values, and cs1_n held low is ignored until it toggles.

Source files
------------

// File: rtl/external_io_fifo.sv
`default_nettype none
// ============================================================================
// Module   : external_io_fifo
// Brief    : Oversampled SPI front end: job config, device config, result FIFO
// Revision : 1.0
// ============================================================================
module external_io_fifo #(
  parameter int JOB_CONFIG_WIDTH    = 8,
  parameter int DEVICE_CONFIG_WIDTH = 8,
  parameter int RESULT_WIDTH        = 40,
  parameter int RESULT_DEPTH        = 4,
  parameter int SYNC_STAGES         = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               sck0,
  input  logic                               sdi0,
  input  logic                               cs0_n,
  input  logic                               sck1,
  input  logic                               sdi1,
  output logic                               sdo1,
  input  logic                               cs1_n,
  output logic [DEVICE_CONFIG_WIDTH-1:0]     device_config,
  output logic [JOB_CONFIG_WIDTH-1:0]        job_config,
  output logic                               core_reset_n,
  input  logic                               shapool_success,
  input  logic [RESULT_WIDTH-1:0]            shapool_result,
  output logic [$clog2(RESULT_DEPTH+1)-1:0]  result_count,
  output logic                               overflow,
  output logic                               ready
);

  localparam int C_CNT_W  = $clog2(RESULT_DEPTH + 1);
  localparam int C_PTR_W  = $clog2(RESULT_DEPTH);
  localparam int C_C0_W   = $clog2(JOB_CONFIG_WIDTH + 1);
  localparam int C_S1_MAX = (RESULT_WIDTH > DEVICE_CONFIG_WIDTH) ? RESULT_WIDTH : DEVICE_CONFIG_WIDTH;
  localparam int C_C1_W   = $clog2(C_S1_MAX + 1);

  localparam logic [C_C0_W-1:0]  C_JOB_BITS = C_C0_W'(JOB_CONFIG_WIDTH);
  localparam logic [C_C1_W-1:0]  C_DEV_BITS = C_C1_W'(DEVICE_CONFIG_WIDTH);
  localparam logic [C_C1_W-1:0]  C_RES_BITS = C_C1_W'(RESULT_WIDTH);
  localparam logic [C_C1_W-1:0]  C_S1_SAT   = C_C1_W'(C_S1_MAX);
  localparam logic [C_CNT_W-1:0] C_FULL     = C_CNT_W'(RESULT_DEPTH);

  // Synchronisers reset low so a chip select held low across reset yields no falling edge.
  logic [SYNC_STAGES-1:0] r_s_sck0, r_s_sdi0, r_s_cs0, r_s_sck1, r_s_sdi1, r_s_cs1;
  logic [3:0]             r_prev;
  logic w_sck0, w_sdi0, w_cs0, w_sck1, w_sdi1, w_cs1;
  logic w_sck0_rise, w_cs0_fall, w_cs0_rise;
  logic w_sck1_rise, w_sck1_fall, w_cs1_fall, w_cs1_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s_sck0 <= '0;
      r_s_sdi0 <= '0;
      r_s_cs0  <= '0;
      r_s_sck1 <= '0;
      r_s_sdi1 <= '0;
      r_s_cs1  <= '0;
      r_prev   <= '0;
    end else begin
      r_s_sck0 <= {r_s_sck0[SYNC_STAGES-2:0], sck0};
      r_s_sdi0 <= {r_s_sdi0[SYNC_STAGES-2:0], sdi0};
      r_s_cs0  <= {r_s_cs0[SYNC_STAGES-2:0],  cs0_n};
      r_s_sck1 <= {r_s_sck1[SYNC_STAGES-2:0], sck1};
      r_s_sdi1 <= {r_s_sdi1[SYNC_STAGES-2:0], sdi1};
      r_s_cs1  <= {r_s_cs1[SYNC_STAGES-2:0],  cs1_n};
      r_prev   <= {w_cs1, w_sck1, w_cs0, w_sck0};
    end
  end

  assign w_sck0      = r_s_sck0[SYNC_STAGES-1];
  assign w_sdi0      = r_s_sdi0[SYNC_STAGES-1];
  assign w_cs0       = r_s_cs0[SYNC_STAGES-1];
  assign w_sck1      = r_s_sck1[SYNC_STAGES-1];
  assign w_sdi1      = r_s_sdi1[SYNC_STAGES-1];
  assign w_cs1       = r_s_cs1[SYNC_STAGES-1];
  assign w_sck0_rise = w_sck0 & ~r_prev[0];
  assign w_cs0_fall  = ~w_cs0 & r_prev[1];
  assign w_cs0_rise  = w_cs0 & ~r_prev[1];
  assign w_sck1_rise = w_sck1 & ~r_prev[2];
  assign w_sck1_fall = ~w_sck1 & r_prev[2];
  assign w_cs1_fall  = ~w_cs1 & r_prev[3];
  assign w_cs1_rise  = w_cs1 & ~r_prev[3];

  // ---------------------------------------------------------------- SPI0
  logic [JOB_CONFIG_WIDTH-1:0] r_shadow0;
  logic [C_C0_W-1:0]           r_cnt0;
  logic                        r_active0;
  logic                        r_commit0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow0  <= '0;
      r_cnt0     <= '0;
      r_active0  <= 1'b0;
      r_commit0  <= 1'b0;
      job_config <= '0;
    end else begin
      r_commit0 <= 1'b0;
      if (w_cs0_fall) begin
        r_active0 <= 1'b1;
        r_shadow0 <= '0;
        r_cnt0    <= '0;
      end else if (r_active0) begin
        if (w_cs0_rise) begin
          r_active0 <= 1'b0;
          if (r_cnt0 >= C_JOB_BITS) begin
            job_config <= r_shadow0;
            r_commit0  <= 1'b1;
          end
        end else if (w_sck0_rise) begin
          r_shadow0 <= {r_shadow0[JOB_CONFIG_WIDTH-2:0], w_sdi0};
          if (r_cnt0 != C_JOB_BITS) r_cnt0 <= r_cnt0 + C_C0_W'(1);
        end
      end
    end
  end

  // Held low through the commit decision so the core never sees a one-cycle release.
  assign core_reset_n = ~reset & w_cs0 & ~r_active0 & ~r_commit0;

  // ---------------------------------------------------------------- FIFO storage
  logic [RESULT_WIDTH-1:0] r_mem [RESULT_DEPTH];
  logic [C_PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [C_CNT_W-1:0]      w_count_next;
  logic                    r_success_d;
  logic                    w_push_edge, w_full, w_push, w_pop;

  // ---------------------------------------------------------------- SPI1
  logic [DEVICE_CONFIG_WIDTH-1:0] r_cfg_shift;
  logic [DEVICE_CONFIG_WIDTH-1:0] w_cfg_value;
  logic [RESULT_WIDTH-1:0]        r_rd_shift;
  logic [C_C1_W-1:0]              r_cnt1;
  logic                           r_active1, r_read_mode, r_cfg_bit, r_cfg_pend;

  // A bit sampled on the last rise but not yet shifted still belongs to the payload.
  assign w_cfg_value = r_cfg_pend ? {r_cfg_shift[DEVICE_CONFIG_WIDTH-2:0], r_cfg_bit} : r_cfg_shift;
  assign w_pop       = r_active1 & r_read_mode & w_cs1_rise & (r_cnt1 >= C_RES_BITS);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cfg_shift   <= '0;
      r_rd_shift    <= '0;
      r_cnt1        <= '0;
      r_active1     <= 1'b0;
      r_read_mode   <= 1'b0;
      r_cfg_bit     <= 1'b0;
      r_cfg_pend    <= 1'b0;
      device_config <= '0;
    end else if (w_cs1_fall) begin
      r_active1   <= 1'b1;
      r_cnt1      <= '0;
      r_cfg_pend  <= 1'b0;
      r_read_mode <= (result_count != '0);
      r_cfg_shift <= device_config;
      r_rd_shift  <= r_mem[r_rd_ptr];
    end else if (r_active1) begin
      if (w_cs1_rise) begin
        r_active1 <= 1'b0;
        if (!r_read_mode && (r_cnt1 >= C_DEV_BITS)) device_config <= w_cfg_value;
      end else begin
        if (w_sck1_rise) begin
          if (r_cnt1 != C_S1_SAT) r_cnt1 <= r_cnt1 + C_C1_W'(1);
          r_cfg_bit  <= w_sdi1;
          r_cfg_pend <= 1'b1;
        end
        if (w_sck1_fall) begin
          if (r_read_mode) begin
            r_rd_shift <= {r_rd_shift[RESULT_WIDTH-2:0], 1'b0};
          end else if (r_cfg_pend) begin
            r_cfg_shift <= {r_cfg_shift[DEVICE_CONFIG_WIDTH-2:0], r_cfg_bit};
            r_cfg_pend  <= 1'b0;
          end
        end
      end
    end
  end

  assign sdo1 = r_active1 & ~w_cs1 &
                (r_read_mode ? r_rd_shift[RESULT_WIDTH-1] : r_cfg_shift[DEVICE_CONFIG_WIDTH-1]);

  // ---------------------------------------------------------------- FIFO control
  assign w_push_edge = shapool_success & ~r_success_d;
  assign w_full      = (result_count == C_FULL);
  assign w_push      = w_push_edge & (~w_full | w_pop);

  always_comb begin
    w_count_next = result_count;
    if (w_push && !w_pop)      w_count_next = result_count + C_CNT_W'(1);
    else if (!w_push && w_pop) w_count_next = result_count - C_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= shapool_result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_success_d  <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      result_count <= '0;
      overflow     <= 1'b0;
      ready        <= 1'b0;
    end else begin
      r_success_d  <= shapool_success;
      if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
      if (w_push_edge && w_full && !w_pop) overflow <= 1'b1;
      result_count <= w_count_next;
      ready        <= (w_count_next != '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_external_io_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_external_io_fifo
// Brief    : Directed scoreboard bench for external_io_fifo
// Revision : 1.1
// ============================================================================
module tb_external_io_fifo;

    logic        clk = 1'b0;
    logic        reset, sck0, sdi0, cs0_n, sck1, sdi1, cs1_n;
    logic        sdo1, core_reset_n, overflow, ready, shapool_success;
    logic [7:0]  device_config, job_config;
    logic [39:0] shapool_result;
    logic [2:0]  result_count;

    external_io_fifo dut (
        .clk(clk), .reset(reset), .sck0(sck0), .sdi0(sdi0), .cs0_n(cs0_n),
        .sck1(sck1), .sdi1(sdi1), .sdo1(sdo1), .cs1_n(cs1_n),
        .device_config(device_config), .job_config(job_config),
        .core_reset_n(core_reset_n), .shapool_success(shapool_success),
        .shapool_result(shapool_result), .result_count(result_count),
        .overflow(overflow), .ready(ready)
    );

    always #5 clk = ~clk;

    typedef enum int {K_JOB, K_DEV, K_CRN, K_SDO, K_CNT, K_RDY, K_OVF, K_WORD} kind_t;
    typedef struct {
        kind_t       kind;
        string       name;
        logic [63:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] got_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        mon_e;
    logic [63:0] mon_act;
    logic [63:0] word;

    task automatic expect_v(input kind_t k, input string nm, input logic [63:0] v);
        exp_t e;
        e.kind = k;
        e.name = nm;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    // Monitor: drains every pending expectation against the DUT on the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            case (mon_e.kind)
                K_JOB:   mon_act = 64'(job_config);
                K_DEV:   mon_act = 64'(device_config);
                K_CRN:   mon_act = 64'(core_reset_n);
                K_SDO:   mon_act = 64'(sdo1);
                K_CNT:   mon_act = 64'(result_count);
                K_RDY:   mon_act = 64'(ready);
                K_OVF:   mon_act = 64'(overflow);
                default: mon_act = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            endcase
            n_cmp++;
            if (mon_act !== mon_e.val) begin
                n_bad++;
                $display("FAIL %s: got %0h expected %0h", mon_e.name, mon_act, mon_e.val);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi0_xfer(input logic [31:0] data, input int nbits);
        cs0_n = 1'b0;
        tick(4);
        expect_v(K_CRN, "crn_cs0_low", 64'd0);
        for (int i = nbits - 1; i >= 0; i--) begin
            sdi0 = data[i];
            tick(4);
            sck0 = 1'b1;
            tick(4);
            sck0 = 1'b0;
        end
        tick(4);
        cs0_n = 1'b1;
    endtask

    task automatic sck1_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            tick(4);
            sck1 = 1'b1;
            tick(4);
            sck1 = 1'b0;
        end
    endtask

    // Host samples sdo1 just before each sck1 rise (mode 0).
    task automatic spi1_xfer(input logic [63:0] data, input int nbits, output logic [63:0] got);
        got   = '0;
        cs1_n = 1'b0;
        tick(4);
        for (int i = nbits - 1; i >= 0; i--) begin
            sdi1 = data[i];
            tick(4);
            got  = {got[62:0], sdo1};
            sck1 = 1'b1;
            tick(4);
            sck1 = 1'b0;
        end
        tick(4);
        cs1_n = 1'b1;
    endtask

    task automatic push_result(input logic [39:0] v);
        shapool_result  = v;
        shapool_success = 1'b1;
        tick(1);
        shapool_success = 1'b0;
        tick(1);
    endtask

    task automatic read_word(input string nm, input logic [63:0] exp_word);
        logic [63:0] g;
        spi1_xfer(64'hFFFF_FFFF_FFFF_FFFF, 40, g);
        got_q.push_back(g);
        expect_v(K_WORD, nm, exp_word);
        tick(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; sck0 = 1'b0; sdi0 = 1'b0; cs0_n = 1'b1;
        sck1 = 1'b0; sdi1 = 1'b0; cs1_n = 1'b1;
        shapool_success = 1'b0; shapool_result = '0;
        tick(3);
        expect_v(K_JOB, "rst_job", 0);
        expect_v(K_DEV, "rst_dev", 0);
        expect_v(K_SDO, "rst_sdo", 0);
        expect_v(K_CRN, "rst_crn", 0);
        expect_v(K_CNT, "rst_cnt", 0);
        expect_v(K_OVF, "rst_ovf", 0);
        expect_v(K_RDY, "rst_rdy", 0);
        reset = 1'b0;
        tick(4);
        expect_v(K_CRN, "crn_idle", 1);

        // SPI0 full commit of 8'hAA
        spi0_xfer(32'hAA, 8);
        tick(2);
        expect_v(K_JOB, "job_before_commit", 0);
        expect_v(K_CRN, "crn_before_commit", 0);
        tick(1);
        expect_v(K_JOB, "job_commit_aa", 64'hAA);
        expect_v(K_CRN, "crn_commit_cycle", 0);
        tick(1);
        expect_v(K_CRN, "crn_released", 1);

        // SPI0 short transfer is discarded
        spi0_xfer(32'h15, 5);
        tick(3);
        expect_v(K_JOB, "job_short_keep", 64'hAA);
        expect_v(K_CRN, "crn_after_short", 1);

        // SPI1 config: load AA, then 5A with AA streaming out, then a 7-bit discard
        spi1_xfer(64'hAA, 8, word);
        got_q.push_back(word);
        expect_v(K_WORD, "cfg_out_zero", 64'h00);
        tick(3);
        expect_v(K_DEV, "dev_aa", 64'hAA);
        spi1_xfer(64'h5A, 8, word);
        got_q.push_back(word);
        expect_v(K_WORD, "cfg_out_aa", 64'hAA);
        tick(3);
        expect_v(K_DEV, "dev_5a", 64'h5A);
        spi1_xfer(64'h33, 7, word);
        got_q.push_back(word);
        expect_v(K_WORD, "cfg_out_7bit", 64'h2D);
        tick(3);
        expect_v(K_DEV, "dev_7bit_keep", 64'h5A);

        // Two results, read in order
        push_result(40'hAA_EEDDCCBB);
        push_result(40'h11_22334455);
        tick(2);
        expect_v(K_CNT, "cnt_two", 2);
        expect_v(K_RDY, "rdy_two", 1);
        expect_v(K_SDO, "sdo_idle", 0);
        read_word("read_first", 64'hAA_EEDDCCBB);
        expect_v(K_CNT, "cnt_after_first", 1);
        read_word("read_second", 64'h11_22334455);
        expect_v(K_CNT, "cnt_empty", 0);
        expect_v(K_RDY, "rdy_empty", 0);
        expect_v(K_DEV, "dev_read_untouched", 64'h5A);

        // Aborted read retains the entry
        push_result(40'h0F_1E2D3C4B);
        expect_v(K_CNT, "cnt_abort_pre", 1);
        spi1_xfer(64'hFFF, 12, word);
        got_q.push_back(word);
        expect_v(K_WORD, "abort_12bits", 64'h0F1);
        tick(3);
        expect_v(K_CNT, "cnt_abort_keep", 1);
        read_word("read_after_abort", 64'h0F_1E2D3C4B);
        expect_v(K_CNT, "cnt_abort_done", 0);

        // Overflow: fifth push dropped
        push_result(40'hC1_00000011);
        push_result(40'hC2_00000022);
        push_result(40'hC3_00000033);
        push_result(40'hC4_00000044);
        expect_v(K_CNT, "cnt_full", 4);
        expect_v(K_OVF, "ovf_not_yet", 0);
        push_result(40'hC5_00000055);
        expect_v(K_CNT, "cnt_full_keep", 4);
        expect_v(K_OVF, "ovf_set", 1);
        read_word("ovf_read1", 64'hC1_00000011);
        read_word("ovf_read2", 64'hC2_00000022);
        read_word("ovf_read3", 64'hC3_00000033);
        read_word("ovf_read4", 64'hC4_00000044);
        expect_v(K_CNT, "ovf_drained", 0);
        expect_v(K_OVF, "ovf_sticky", 1);

        // Reset mid-read; cs1_n held low afterwards must be ignored
        push_result(40'hF0_00000001);
        cs1_n = 1'b0;
        tick(4);
        expect_v(K_SDO, "sdo_read_msb", 1);
        sck1_pulses(5);
        reset = 1'b1;
        tick(2);
        expect_v(K_JOB, "mid_rst_job", 0);
        expect_v(K_DEV, "mid_rst_dev", 0);
        expect_v(K_SDO, "mid_rst_sdo", 0);
        expect_v(K_CRN, "mid_rst_crn", 0);
        expect_v(K_CNT, "mid_rst_cnt", 0);
        expect_v(K_OVF, "mid_rst_ovf", 0);
        expect_v(K_RDY, "mid_rst_rdy", 0);
        reset = 1'b0;
        tick(4);
        push_result(40'hF0_00000001);
        sck1_pulses(3);
        expect_v(K_SDO, "held_cs_sdo", 0);
        sck1_pulses(42);
        cs1_n = 1'b1;
        tick(4);
        expect_v(K_CNT, "held_cs_no_pop", 1);
        expect_v(K_RDY, "held_cs_rdy", 1);
        read_word("fresh_read", 64'hF0_00000001);
        expect_v(K_CNT, "fresh_read_pop", 0);

        tick(4);

        n_cmp++;
        if (job_config !== 8'h00) begin
            n_bad++;
            $display("FAIL final_job: got %0h expected 0", job_config);
        end
        n_cmp++;
        if (device_config !== 8'h00) begin
            n_bad++;
            $display("FAIL final_dev: got %0h expected 0", device_config);
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL final_ovf: got %0b expected 0", overflow);
        end
        if (n_cmp < 12) begin
            n_bad++;
            $display("FAIL too few comparisons executed: %0d", n_cmp);
        end
        if (n_bad == 0) $display("PASS");
        else            $display("FAIL");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
